prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader sitting directly upstream of the machine's RAM and CPU reset. It accepts a framed program image over a simple valid/ready byte interface, writes it into RAM, and holds the CPU in reset until a complete frame with a correct checksum has been stored. This replaces simulation-only memory preloading with a synthesizable boot path.

## Interface
- `ADDR_W`, 8: RAM address width; fixed at 8 for this machine.
- `TIMEOUT_CYC`, 1024: inter-byte timeout in clk cycles. Used only with `LOADER_TIMEOUT_EN`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers when `rx_valid && rx_ready` at a rising edge.
- `mem_addr`  out  8  RAM write address, registered.
- `mem_wdata`  out  8  RAM write data, registered.
- `mem_we`  out  1  RAM write strobe, one-cycle pulse.
- `cpu_reset`  out  1  active-high reset to the CPU.
- `load_done`  out  1  the last frame was loaded and verified, and the CPU is running.
- `load_err`  out  1  the last frame failed the checksum or timed out.

## Operation
- Frame format: `0xA5` header, LEN byte, START address byte, LEN data bytes, then a CSUM byte.
  - LEN=0 means 256 data bytes.
  - CSUM is the 8-bit modulo-256 sum of the data bytes only.
- States: IDLE, LEN, ADDR, DATA, CSUM, RUN, ERR.
- IDLE:
  - `0xA5` moves to LEN.
  - Any other byte is accepted and discarded.
- LEN: latch the count (0 is treated as 256) and move to ADDR.
- ADDR: load the address pointer, clear the running sum, and move to DATA.
- DATA: each accepted byte is written at the pointer.
  - The pointer increments modulo 256; 0xFF wraps to 0x00.
  - The byte is added to the running sum and the count decrements.
  - When the final byte is accepted, move to CSUM.
- CSUM:
  - If the byte equals the running sum, move to RUN.
  - Otherwise move to ERR.
- RUN:
  - `cpu_reset`=0 and `load_done`=1.
  - `0xA5` re-enters LEN: `cpu_reset`=1 and `load_done`=0 on the next cycle.
  - Other bytes are discarded.
- ERR:
  - `cpu_reset`=1 and `load_err`=1.
  - `0xA5` clears `load_err` and enters LEN.
  - Other bytes are discarded.
  - RAM contents written before the error are not rolled back.
- A header byte inside LEN, ADDR, DATA or CSUM is treated as ordinary frame data; there is no resynchronisation mid-frame.
- `rx_ready` is 1 in every state once reset is released. The loader never back-pressures.

## Timing
- Reset values:
  - state=IDLE.
  - `rx_ready`=0, `mem_addr`=0x00, `mem_wdata`=0x00, `mem_we`=0.
  - `cpu_reset`=1, `load_done`=0, `load_err`=0.
- `rx_ready` rises on the first clock edge after reset deasserts.
- Write latency: a data byte accepted at edge N produces `mem_we`=1 with matching `mem_addr`/`mem_wdata` during the cycle after edge N, and `mem_we` drops after edge N+1.
  - Back-to-back bytes give back-to-back write cycles.
- The CSUM byte is accepted at edge N:
  - On a match, `cpu_reset` falls and `load_done` rises after edge N.
  - On a mismatch, `load_err` rises after edge N.
- The last data write completes before the CPU leaves reset, because `mem_we` for the last byte is high in the same cycle that CSUM is presented or earlier.
- Asserting reset mid-frame immediately returns all outputs to reset values, including aborting any pending `mem_we`. The partial frame is lost.

## Configuration
- `LOADER_TIMEOUT_EN` defined: an inter-byte counter runs in LEN, ADDR, DATA and CSUM.
  - The counter clears on every accepted byte.
  - Reaching `TIMEOUT_CYC` cycles with no byte moves to ERR and sets `load_err`=1.
- `LOADER_TIMEOUT_EN` undefined: the counter is absent and the loader waits indefinitely mid-frame.

## Test plan
- Basic load:
  - Stimulus: send A5 03 10 11 22 33 66.
  - Required: writes 0x10=11, 0x11=22, 0x12=33. One cycle after the 66 byte, `cpu_reset`=0, `load_done`=1, `load_err`=0.
- Bad checksum:
  - Stimulus: send A5 02 00 01 02 04.
  - Required: both writes occur, `cpu_reset` stays 1, `load_err`=1.
  - Follow-up: a following valid frame clears `load_err` and releases reset.
- Wrap and maximum length:
  - Stimulus: send A5 00 F0, then 256 bytes of 0x01, then CSUM 0x00.
  - Required: 256 writes with addresses F0..FF then 00..EF, and the frame passes.
- Reload while running:
  - Stimulus: after a good load, send A5 01 40 7E 7E.
  - Required: `cpu_reset`=1 and `load_done`=0 the cycle after A5. Write 0x40=7E. Reset is released again after CSUM.
- Garbage and reset mid-frame:
  - Stimulus: send 00 FF 5A in IDLE.
  - Required: no writes occur.
  - Stimulus: assert reset after A5 03 10 11.
  - Required: all outputs return to reset values immediately.
- Timeout:
  - Condition: `LOADER_TIMEOUT_EN` defined, `TIMEOUT_CYC`=16.
  - Stimulus: send A5 02, then idle for 16 cycles.
  - Required: `load_err`=1 and `cpu_reset`=1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream boot loader. It writes the image into RAM and holds the CPU in reset until the checksum passes.
// Defining LOADER_TIMEOUT_EN adds an inter-byte timeout of TIMEOUT_CYC clocks while a frame is in progress.
module prog_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);
    // state  | meaning
    // S_IDLE | waiting for the 0xA5 header; other bytes are dropped
    // S_LEN  | next byte is the data count (0 means 256)
    // S_ADDR | next byte is the start address
    // S_DATA | data bytes are written to RAM and summed
    // S_CSUM | next byte is compared with the running sum
    // S_RUN  | image verified, CPU released
    // S_ERR  | checksum or timeout failure, CPU held in reset
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_ADDR, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    localparam logic [7:0] HDR = 8'hA5;

    if (TIMEOUT_CYC < 1) begin : g_tmo_param_chk
        $error("prog_loader: TIMEOUT_CYC must be at least 1");
    end

    state_t            state_q;
    logic [8:0]        cnt_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        sum_q;
    logic              rx_ready_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q;
    logic              cpu_reset_q;
    logic              load_done_q;
    logic              load_err_q;
    logic              accept_d;
    logic              timeout_d;

    assign accept_d = rx_valid && rx_ready_q;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
    logic          in_frame_d;

    assign in_frame_d = state_q inside {S_LEN, S_ADDR, S_DATA, S_CSUM};

    // Down-counter reloaded by every accepted byte; terminal count means TIMEOUT_CYC idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= TW'(TIMEOUT_CYC - 1);
        end else if (accept_d || !in_frame_d) begin
            tmo_q <= TW'(TIMEOUT_CYC - 1);
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - TW'(1);
        end
    end

    assign timeout_d = in_frame_d && !accept_d && (tmo_q == '0);
`else
    assign timeout_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            sum_q       <= '0;
            rx_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            rx_ready_q <= 1'b1;
            mem_we_q   <= 1'b0;
            if (timeout_d) begin
                state_q    <= S_ERR;
                load_err_q <= 1'b1;
            end else if (accept_d) begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_data == HDR) state_q <= S_LEN;
                    end
                    S_LEN: begin
                        cnt_q   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        state_q <= S_ADDR;
                    end
                    S_ADDR: begin
                        ptr_q   <= rx_data[ADDR_W-1:0];
                        sum_q   <= '0;
                        state_q <= S_DATA;
                    end
                    S_DATA: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= rx_data;
                        ptr_q       <= ptr_q + ADDR_W'(1);
                        sum_q       <= sum_q + rx_data;
                        cnt_q       <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) state_q <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (rx_data == sum_q) begin
                            state_q     <= S_RUN;
                            cpu_reset_q <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (rx_data == HDR) begin
                            state_q     <= S_LEN;
                            cpu_reset_q <= 1'b1;
                            load_done_q <= 1'b0;
                        end
                    end
                    S_ERR: begin
                        if (rx_data == HDR) begin
                            state_q    <= S_LEN;
                            load_err_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_reset = cpu_reset_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed frames plus randomized frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       cpu_reset;
    logic       load_done;
    logic       load_err;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_err(load_err)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         gap_max = 0;
    int         wr_cnt  = 0;
    logic [7:0] ram     [256];
    bit         ram_wr  [256];
    logic [7:0] ref_mem [256];
    bit         ref_wr  [256];
    bit         exp_done = 1'b0;
    bit         exp_err  = 1'b0;
    logic [7:0] frame_q [$];

    // RAM stand-in fed by the write strobe
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"},  rx_ready,  1'b0);
        chk({tag, "_mem_addr"},  mem_addr,  8'h00);
        chk({tag, "_mem_wdata"}, mem_wdata, 8'h00);
        chk({tag, "_mem_we"},    mem_we,    1'b0);
        chk({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        chk({tag, "_load_done"}, load_done, 1'b0);
        chk({tag, "_load_err"},  load_err,  1'b0);
    endtask

    // Called 1ns after a falling edge; returns 1ns after the falling edge that follows the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int unsigned g;
        g = $urandom_range(gap_max, 0);
        repeat (g) begin
            @(negedge clk);
            #1;
        end
        chk("rx_ready", rx_ready, 1'b1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic junk_byte(input logic [7:0] b);
        send_byte(b);
        chk("junk_we",   mem_we,    1'b0);
        chk("junk_cpu",  cpu_reset, !exp_done);
        chk("junk_done", load_done, exp_done);
        chk("junk_err",  load_err,  exp_err);
    endtask

    task automatic rand_junk(input int k);
        int         w0;
        logic [7:0] b;
        w0 = wr_cnt;
        for (int i = 0; i < k; i++) begin
            do b = 8'($urandom); while (b == 8'hA5);
            junk_byte(b);
        end
        chk("junk_writes", wr_cnt - w0, 0);
    endtask

    // Sends header, LEN, START, frame_q contents and csum; expectations follow from the frame itself.
    task automatic send_frame(input logic [7:0] start, input logic [7:0] csum);
        int         n;
        int         w0;
        logic [7:0] sum;
        logic [7:0] a;
        bit         pass;
        n   = frame_q.size();
        sum = 8'h00;
        send_byte(8'hA5);
        chk("hdr_cpu_reset", cpu_reset, 1'b1);
        chk("hdr_load_done", load_done, 1'b0);
        chk("hdr_load_err",  load_err,  1'b0);
        send_byte((n == 256) ? 8'h00 : 8'(n));
        send_byte(start);
        chk("hdr_no_we", mem_we, 1'b0);
        w0 = wr_cnt;
        for (int i = 0; i < n; i++) begin
            a = start + 8'(i);
            send_byte(frame_q[i]);
            chk("wr_we",    mem_we,    1'b1);
            chk("wr_addr",  mem_addr,  a);
            chk("wr_wdata", mem_wdata, frame_q[i]);
            ref_mem[a] = frame_q[i];
            ref_wr[a]  = 1'b1;
            sum        = sum + frame_q[i];
        end
        chk("data_cpu_held", cpu_reset, 1'b1);
        send_byte(csum);
        pass = (csum == sum);
        chk("frame_writes",   wr_cnt - w0, n);
        chk("csum_no_we",     mem_we,    1'b0);
        chk("csum_cpu_reset", cpu_reset, !pass);
        chk("csum_load_done", load_done, pass);
        chk("csum_load_err",  load_err,  !pass);
        exp_done = pass;
        exp_err  = !pass;
    endtask

    task automatic rand_frame(input int n, input bit corrupt);
        logic [7:0] s;
        s = 8'h00;
        frame_q.delete();
        for (int i = 0; i < n; i++) begin
            frame_q.push_back(8'($urandom));
            s = s + frame_q[i];
        end
        if (corrupt) s = s + 8'($urandom_range(255, 1));
        send_frame(8'($urandom), s);
    endtask

    initial begin
        int w0;
        int bad;
        int n;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        #1;
        chk("rx_ready_before_edge", rx_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("rx_ready_after_edge", rx_ready, 1'b1);

        // garbage in idle
        w0 = wr_cnt;
        junk_byte(8'h00);
        junk_byte(8'hFF);
        junk_byte(8'h5A);
        chk("idle_garbage_writes", wr_cnt - w0, 0);

        // basic load
        frame_q.delete();
        frame_q.push_back(8'h11);
        frame_q.push_back(8'h22);
        frame_q.push_back(8'h33);
        send_frame(8'h10, 8'h66);

        // bad checksum, then recovery
        frame_q.delete();
        frame_q.push_back(8'h01);
        frame_q.push_back(8'h02);
        send_frame(8'h00, 8'h04);
        rand_junk(2);
        rand_frame(5, 1'b0);

        // reload while running
        frame_q.delete();
        frame_q.push_back(8'h7E);
        send_frame(8'h40, 8'h7E);
        rand_junk(2);

        // wrap and maximum length
        frame_q.delete();
        for (int i = 0; i < 256; i++) frame_q.push_back(8'h01);
        send_frame(8'hF0, 8'h00);

        // reset mid-frame aborts the pending write
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h10);
        send_byte(8'h11);
        chk("abort_we_pending", mem_we, 1'b1);
        ref_mem[8'h10] = 8'h11;
        ref_wr[8'h10]  = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("midframe");
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        @(negedge clk);
        #1;
        chk("rx_ready_after_rerelease", rx_ready, 1'b1);
        rand_junk(2);
        rand_frame(3, 1'b0);

`ifdef LOADER_TIMEOUT_EN
        send_byte(8'hA5);
        send_byte(8'h02);
        repeat (15) @(negedge clk);
        #1;
        chk("tmo_not_yet", load_err, 1'b0);
        @(negedge clk);
        #1;
        chk("tmo_load_err",  load_err,  1'b1);
        chk("tmo_cpu_reset", cpu_reset, 1'b1);
        chk("tmo_load_done", load_done, 1'b0);
        exp_done = 1'b0;
        exp_err  = 1'b1;
        rand_junk(2);
        rand_frame(4, 1'b0);
`endif

        // randomized frames with input bubbles
        gap_max = 3;
        for (int it = 0; it < 25; it++) begin
            rand_junk($urandom_range(3, 0));
            n = ($urandom_range(9, 0) == 0) ? 256 : $urandom_range(40, 1);
            rand_frame(n, $urandom_range(2, 0) == 0);
        end
        gap_max = 0;

        bad = 0;
        for (int a = 0; a < 256; a++) begin
            if (ref_wr[a] != ram_wr[a]) bad++;
            else if (ref_wr[a] && (ram[a] !== ref_mem[a])) bad++;
        end
        chk("ram_image_mismatches", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
